// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// A prescaler divides the clock into digit slots, and a 2-bit index steps through the digits once per slot.
// Each slot starts with a few dark cycles so the previous digit does not ghost onto the next one.
// Leading zero digits can be blanked, unless a decimal point is lit on or above them.
// Every output is a flop, so no input has a combinational path to an output.
module seven_seg_scan_driver #(
    parameter int TICK_DIVISOR  = 100000,
    parameter int DEAD_CYCLES   = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        loadValue,
    input  logic [15:0] valueIn,
    input  logic [3:0]  dpIn,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        decimalPoint,
    output logic [1:0]  digitSelect,
    output logic        scanTick
);

    localparam int PW = (TICK_DIVISOR > 2) ? $clog2(TICK_DIVISOR) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIVISOR - 1);
    localparam logic [PW-1:0] DEAD_LIMIT    = PW'(DEAD_CYCLES);

    logic [PW-1:0] prescaler;
    logic [15:0]   shownValue;
    logic [3:0]    shownDp;

    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic [3:0]    digit_used;
    logic [3:0]    blank_vec;
    logic          digit_blank;
    logic          in_dead_time;

    // Select the nibble for the current digit and look up its active-low glyph (g..a).
    always_comb begin
        nibble = shownValue[{digitSelect, 2'b00} +: 4];
        glyph  = 7'b1111111;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
    end

    // A digit counts as leading-blank only if it and every digit to its left hold 0 with no DP lit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_used[i] = (|shownValue[4*i +: 4]) | shownDp[i];
        end
        blank_vec[3] = ~digit_used[3];
        blank_vec[2] = ~(digit_used[3] | digit_used[2]);
        blank_vec[1] = ~(digit_used[3] | digit_used[2] | digit_used[1]);
        blank_vec[0] = 1'b0;
        digit_blank  = BLANK_LEADING ? blank_vec[digitSelect] : 1'b0;
        in_dead_time = (prescaler < DEAD_LIMIT);
    end

    // Scan state: the prescaler, the digit index, the tick pulse and the latched display data.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler   <= '0;
            digitSelect <= 2'd0;
            scanTick    <= 1'b0;
            shownValue  <= 16'h0000;
            shownDp     <= 4'b0000;
        end else begin
            scanTick <= 1'b0;
            if (loadValue) begin
                shownValue <= valueIn;
                shownDp    <= dpIn;
            end
            if (enable) begin
                if (prescaler == PRESCALE_LAST) begin
                    prescaler   <= '0;
                    digitSelect <= digitSelect + 2'd1;
                    scanTick    <= 1'b1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    // Display outputs are registered from the state as it stands this cycle, so they lag the state by one clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            anodes       <= 4'b1111;
            segments     <= 7'b1111111;
            decimalPoint <= 1'b1;
        end else begin
            segments     <= glyph;
            decimalPoint <= ~shownDp[digitSelect];
            if (!enable || in_dead_time || digit_blank) begin
                anodes <= 4'b1111;
            end else begin
                anodes <= ~(4'b0001 << digitSelect);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with TICK_DIVISOR=8, DEAD_CYCLES=2, BLANK_LEADING=1.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_seven_seg_scan_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        loadValue;
    logic [15:0] valueIn;
    logic [3:0]  dpIn;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        decimalPoint;
    logic [1:0]  digitSelect;
    logic        scanTick;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_F = 7'b0001110;

    seven_seg_scan_driver #(
        .TICK_DIVISOR (8),
        .DEAD_CYCLES  (2),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .loadValue   (loadValue),
        .valueIn     (valueIn),
        .dpIn        (dpIn),
        .anodes      (anodes),
        .segments    (segments),
        .decimalPoint(decimalPoint),
        .digitSelect (digitSelect),
        .scanTick    (scanTick)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Run the last 5 edges of a slot that is at prescaler 3 and check the tick and the digit advance.
    task automatic finish_slot(input string tag, input logic [1:0] next_digit);
        step(4);
        chk({tag, "_tick_before_wrap"}, {31'd0, scanTick}, 32'd0);
        step(1);
        chk({tag, "_tick_at_wrap"}, {31'd0, scanTick}, 32'd1);
        chk({tag, "_digit_after_wrap"}, {30'd0, digitSelect}, {30'd0, next_digit});
    endtask

    initial begin
        // Reset, with a load asserted that reset must override
        reset     = 1'b1;
        enable    = 1'b0;
        loadValue = 1'b1;
        valueIn   = 16'hFFFF;
        dpIn      = 4'hF;
        step(2);
        chk("rst_anodes", {28'd0, anodes}, 32'hF);
        chk("rst_segments", {25'd0, segments}, 32'h7F);
        chk("rst_dp", {31'd0, decimalPoint}, 32'd1);
        chk("rst_digit", {30'd0, digitSelect}, 32'd0);
        chk("rst_tick", {31'd0, scanTick}, 32'd0);

        reset     = 1'b0;
        loadValue = 1'b0;
        valueIn   = 16'h0000;
        dpIn      = 4'h0;
        enable    = 1'b1;
        step(1);
        chk("rel_dead_anodes", {28'd0, anodes}, 32'hF);
        step(2);
        chk("rel_d0_anodes", {28'd0, anodes}, 32'hE);
        chk("rel_d0_segments", {25'd0, segments}, {25'd0, SEG_0});

        // Load 12AF while slot 0 is at prescaler 3
        loadValue = 1'b1;
        valueIn   = 16'h12AF;
        step(1);
        loadValue = 1'b0;
        step(1);
        chk("v12af_d0_anodes", {28'd0, anodes}, 32'hE);
        chk("v12af_d0_segments", {25'd0, segments}, {25'd0, SEG_F});
        step(2);
        chk("v12af_no_tick", {31'd0, scanTick}, 32'd0);
        step(1);
        chk("v12af_tick0", {31'd0, scanTick}, 32'd1);
        chk("v12af_digit1", {30'd0, digitSelect}, 32'd1);
        step(1);
        chk("v12af_tick_pulse", {31'd0, scanTick}, 32'd0);
        chk("v12af_d1_dead", {28'd0, anodes}, 32'hF);
        step(2);
        chk("v12af_d1_anodes", {28'd0, anodes}, 32'hD);
        chk("v12af_d1_segments", {25'd0, segments}, {25'd0, SEG_A});
        finish_slot("v12af_s1", 2'd2);
        step(3);
        chk("v12af_d2_anodes", {28'd0, anodes}, 32'hB);
        chk("v12af_d2_segments", {25'd0, segments}, {25'd0, SEG_2});
        finish_slot("v12af_s2", 2'd3);
        step(3);
        chk("v12af_d3_anodes", {28'd0, anodes}, 32'h7);
        chk("v12af_d3_segments", {25'd0, segments}, {25'd0, SEG_1});
        finish_slot("v12af_s3_wrap", 2'd0);

        // 0005 with no decimal points: only digit 0 is lit
        loadValue = 1'b1;
        valueIn   = 16'h0005;
        dpIn      = 4'b0000;
        step(1);
        loadValue = 1'b0;
        step(2);
        chk("v0005_d0_anodes", {28'd0, anodes}, 32'hE);
        chk("v0005_d0_segments", {25'd0, segments}, {25'd0, SEG_5});
        finish_slot("v0005_s0", 2'd1);
        for (int i = 0; i < 24; i++) begin
            step(1);
            chk("v0005_blank_slots", {28'd0, anodes}, 32'hF);
        end
        chk("v0005_back_to_d0", {30'd0, digitSelect}, 32'd0);

        // All zeros: digit 0 still shows 0
        loadValue = 1'b1;
        valueIn   = 16'h0000;
        step(1);
        loadValue = 1'b0;
        step(2);
        chk("v0000_d0_anodes", {28'd0, anodes}, 32'hE);
        chk("v0000_d0_segments", {25'd0, segments}, {25'd0, SEG_0});
        finish_slot("v0000_s0", 2'd1);

        // 0005 with the DP on digit 2: digits 1 and 2 unblank, digit 3 stays blank
        loadValue = 1'b1;
        valueIn   = 16'h0005;
        dpIn      = 4'b0100;
        step(1);
        loadValue = 1'b0;
        step(2);
        chk("dp2_d1_anodes", {28'd0, anodes}, 32'hD);
        chk("dp2_d1_segments", {25'd0, segments}, {25'd0, SEG_0});
        chk("dp2_d1_dp", {31'd0, decimalPoint}, 32'd1);
        finish_slot("dp2_s1", 2'd2);
        step(3);
        chk("dp2_d2_anodes", {28'd0, anodes}, 32'hB);
        chk("dp2_d2_segments", {25'd0, segments}, {25'd0, SEG_0});
        chk("dp2_d2_dp", {31'd0, decimalPoint}, 32'd0);
        finish_slot("dp2_s2", 2'd3);
        step(3);
        chk("dp2_d3_blank", {28'd0, anodes}, 32'hF);
        chk("dp2_d3_dp", {31'd0, decimalPoint}, 32'd1);
        finish_slot("dp2_s3", 2'd0);
        step(3);
        chk("dp2_d0_anodes", {28'd0, anodes}, 32'hE);
        chk("dp2_d0_segments", {25'd0, segments}, {25'd0, SEG_5});
        finish_slot("dp2_s0", 2'd1);

        // Pause the scan in the middle of slot 1 (prescaler 4)
        step(4);
        chk("pause_pre_anodes", {28'd0, anodes}, 32'hD);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("pause_anodes", {28'd0, anodes}, 32'hF);
            chk("pause_tick", {31'd0, scanTick}, 32'd0);
            chk("pause_digit", {30'd0, digitSelect}, 32'd1);
        end
        enable = 1'b1;
        step(1);
        chk("resume_anodes", {28'd0, anodes}, 32'hD);
        chk("resume_digit", {30'd0, digitSelect}, 32'd1);
        step(2);
        chk("resume_no_tick", {31'd0, scanTick}, 32'd0);
        chk("resume_still_d1", {30'd0, digitSelect}, 32'd1);
        step(1);
        chk("resume_tick", {31'd0, scanTick}, 32'd1);
        chk("resume_digit2", {30'd0, digitSelect}, 32'd2);

        // Load on the wrap edge from slot 3 into slot 0
        step(8);
        chk("wrapload_d3", {30'd0, digitSelect}, 32'd3);
        step(7);
        loadValue = 1'b1;
        valueIn   = 16'h000A;
        dpIn      = 4'b0000;
        step(1);
        loadValue = 1'b0;
        chk("wrapload_tick", {31'd0, scanTick}, 32'd1);
        chk("wrapload_digit0", {30'd0, digitSelect}, 32'd0);
        chk("wrapload_d3_blank", {28'd0, anodes}, 32'hF);
        step(1);
        chk("wrapload_dead_anodes", {28'd0, anodes}, 32'hF);
        chk("wrapload_dead_segments", {25'd0, segments}, {25'd0, SEG_A});
        step(1);
        chk("wrapload_dead2_segments", {25'd0, segments}, {25'd0, SEG_A});
        step(1);
        chk("wrapload_d0_anodes", {28'd0, anodes}, 32'hE);
        chk("wrapload_d0_segments", {25'd0, segments}, {25'd0, SEG_A});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
